// File: rtl/vec_player_capture.sv
// Stimulus player / response capture for combinational benchmark cores.
// Optional 32-bit response MISR enabled by defining VEC_PLAYER_MISR_EN.
module vec_player_capture #(
    parameter int IN_W   = 356,
    parameter int OUT_W  = 246,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH) + 1,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_data,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    num_vec,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             cap_valid,
    output logic [AW-1:0]    cap_index,
    output logic [OUT_W-1:0] cap_data,
    output logic [31:0]      signature
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [IN_W-1:0]  mem [0:(2**IW)-1];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    n_q, n_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] cap_data_q, cap_data_d;
    logic [AW-1:0]    cap_index_q, cap_index_d;
    logic             cap_valid_q, cap_valid_d;
    logic             done_q, done_d;
    logic [AW-1:0]    idx_nxt;
    logic [AW-1:0]    n_start;

    assign idx_nxt = idx_q + AW'(1);
    assign n_start = (num_vec > DEPTH_A) ? DEPTH_A : num_vec;

`ifdef VEC_PLAYER_MISR_EN
    localparam int NCH = (OUT_W + 31) / 32;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    logic [NCH*32-1:0] out_pad;
    logic [31:0]       fold;
    logic [31:0]       sig_q, sig_d, sig_step;

    always_comb begin
        out_pad = '0;
        out_pad[OUT_W-1:0] = dut_out;
        fold = '0;
        for (int k = 0; k < NCH; k++) begin
            fold = fold ^ out_pad[k*32 +: 32];
        end
    end

    assign sig_step  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
    assign signature = sig_q;
`else
    assign signature = '0;
`endif

    // Vector memory is loadable only while idle and is never reset.
    always_ff @(posedge clk) begin
        if (load_we && state_q == S_IDLE && load_addr < DEPTH_A) begin
            mem[load_addr[IW-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dut_in_d    = dut_in_q;
        cap_data_d  = cap_data_q;
        cap_index_d = cap_index_q;
        cap_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef VEC_PLAYER_MISR_EN
        sig_d       = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    n_d = n_start;
`ifdef VEC_PLAYER_MISR_EN
                    sig_d = '0;
`endif
                    if (n_start == '0) begin
                        state_d = S_DONE;
                    end else begin
                        dut_in_d = mem[0];
                        idx_d    = '0;
                        cnt_d    = CNT_INIT;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    cap_data_d  = dut_out;
                    cap_index_d = idx_q;
                    cap_valid_d = 1'b1;
`ifdef VEC_PLAYER_MISR_EN
                    sig_d = sig_step;
`endif
                    if (idx_q == n_q - AW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        dut_in_d = mem[idx_nxt[IW-1:0]];
                        idx_d    = idx_nxt;
                        cnt_d    = CNT_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = !abort;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            cap_data_q  <= '0;
            cap_index_q <= '0;
            cap_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef VEC_PLAYER_MISR_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dut_in_q    <= dut_in_d;
            cap_data_q  <= cap_data_d;
            cap_index_q <= cap_index_d;
            cap_valid_q <= cap_valid_d;
            done_q      <= done_d;
`ifdef VEC_PLAYER_MISR_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign done      = done_q;
    assign cap_valid = cap_valid_q;
    assign cap_index = cap_index_q;
    assign cap_data  = cap_data_q;

endmodule

// File: tb/tb_vec_player_capture.sv
// Bench for vec_player_capture: timeline model of runs, table + random runs.
// CUT is modelled as dut_out = dut_in[OUT_W-1:0].
module tb_vec_player_capture;

    localparam int IN_W  = 356;
    localparam int OUT_W = 246;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int S     = 2;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_we = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [IN_W-1:0]  load_data = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [AW-1:0]    num_vec = '0;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy, done, cap_valid;
    logic [AW-1:0]    cap_index;
    logic [OUT_W-1:0] cap_data;
    logic [31:0]      signature;

    vec_player_capture #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW), .SETTLE(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .abort(abort),
        .num_vec(num_vec), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .cap_valid(cap_valid),
        .cap_index(cap_index), .cap_data(cap_data), .signature(signature)
    );

    assign dut_out = dut_in[OUT_W-1:0];

    always #5 clk = ~clk;

    typedef struct {
        int nv;
        int ak;
        int bw;
        int exp_caps;
        int exp_done;
    } row_t;

    row_t tbl [7];

    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0]  mmem [DEPTH];
    logic [31:0]      sig_m;
    logic [OUT_W-1:0] last_cap;
    logic [IN_W-1:0]  prev_din;

    task automatic chk(input string name, input logic [IN_W-1:0] act,
                       input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s,
                                         input logic [OUT_W-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ d[i];
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [IN_W-1:0] rvec();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        return t[IN_W-1:0];
    endfunction

    task automatic load(input int a, input logic [IN_W-1:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(negedge clk);
        load_we = 1'b0;
        if (a < DEPTH) mmem[a] = d;
    endtask

    // Sample j is taken at the negedge after the j-th edge from the start edge.
    task automatic run(input int nv, input int ak, input int bw,
                       output int caps, output int dones);
        int n, a_edge, last, vi;
        logic [IN_W-1:0]  exp_din;
        logic [OUT_W-1:0] d;
        n      = (nv < DEPTH) ? nv : DEPTH;
        a_edge = (ak >= 0 && ak < n) ? (ak + 1) * S : -1;
        last   = (a_edge >= 0) ? a_edge + 3 : n * S + 3;
        caps   = 0;
        dones  = 0;
        @(negedge clk);
        start   = 1'b1;
        num_vec = AW'(nv);
        sig_m   = '0;
        for (int j = 0; j <= last; j++) begin
            bit ab, eb, ecv, edn;
            @(negedge clk);
            ab  = (a_edge >= 0) && (j >= a_edge);
            eb  = !ab && (j <= n * S);
            ecv = !ab && (j >= S) && (j % S == 0) && (j / S <= n);
            edn = !ab && (a_edge < 0) && (j == n * S + 1);
            if (n > 0) begin
                vi = ab ? ak : ((j / S < n) ? j / S : n - 1);
                exp_din = mmem[vi];
            end else begin
                exp_din = prev_din;
            end
            if (ecv) begin
                d = mmem[j / S - 1][OUT_W-1:0];
                last_cap = d;
`ifdef VEC_PLAYER_MISR_EN
                sig_m = misr(sig_m, d);
`endif
            end
            caps  += int'(cap_valid);
            dones += int'(done);
            chk("busy", IN_W'(busy), IN_W'(eb));
            chk("cap_valid", IN_W'(cap_valid), IN_W'(ecv));
            chk("done", IN_W'(done), IN_W'(edn));
            chk("dut_in", dut_in, exp_din);
            chk("cap_data", IN_W'(cap_data), IN_W'(last_cap));
            chk("signature", IN_W'(signature), IN_W'(sig_m));
            if (ecv) chk("cap_index", IN_W'(cap_index), IN_W'(j / S - 1));
            if (j == last) prev_din = exp_din;
            if (j == 0) start = 1'b0;
            if (a_edge >= 0 && j == a_edge - 1) abort = 1'b1;
            if (j == a_edge) abort = 1'b0;
            if (bw != 0 && j == 1) begin
                load_we   = 1'b1;
                load_addr = '0;
                load_data = ~mmem[0];
            end
            if (bw != 0 && j == 2) load_we = 1'b0;
        end
        start   = 1'b0;
        abort   = 1'b0;
        load_we = 1'b0;
    endtask

    initial begin
        int caps, dones, nv, ak, n;
        tbl[0] = '{nv: 4, ak: -1, bw: 0, exp_caps: 4, exp_done: 1};
        tbl[1] = '{nv: 0, ak: -1, bw: 0, exp_caps: 0, exp_done: 1};
        tbl[2] = '{nv: 7, ak: -1, bw: 0, exp_caps: 4, exp_done: 1};
        tbl[3] = '{nv: 4, ak: 1,  bw: 0, exp_caps: 1, exp_done: 0};
        tbl[4] = '{nv: 4, ak: -1, bw: 1, exp_caps: 4, exp_done: 1};
        tbl[5] = '{nv: 3, ak: 0,  bw: 0, exp_caps: 0, exp_done: 0};
        tbl[6] = '{nv: 1, ak: -1, bw: 0, exp_caps: 1, exp_done: 1};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", IN_W'(busy), '0);
        chk("rst_done", IN_W'(done), '0);
        chk("rst_cap_valid", IN_W'(cap_valid), '0);
        chk("rst_dut_in", dut_in, '0);
        chk("rst_cap_data", IN_W'(cap_data), '0);
        chk("rst_cap_index", IN_W'(cap_index), '0);
        chk("rst_signature", IN_W'(signature), '0);
        rst_n    = 1'b1;
        prev_din = '0;
        last_cap = '0;
        sig_m    = '0;

        for (int a = 0; a < DEPTH; a++) load(a, IN_W'(a + 1));
        load(4, rvec());
        load(7, rvec());

        for (int r = 0; r < 7; r++) begin
            run(tbl[r].nv, tbl[r].ak, tbl[r].bw, caps, dones);
            chk("tbl_caps", IN_W'(caps), IN_W'(tbl[r].exp_caps));
            chk("tbl_done", IN_W'(dones), IN_W'(tbl[r].exp_done));
        end

        // abort wins over start in idle
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        num_vec = 3'd2;
        @(negedge clk);
        chk("idle_abort_busy", IN_W'(busy), '0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy2", IN_W'(busy), '0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start   = 1'b1;
        num_vec = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", IN_W'(busy), '0);
        chk("mid_rst_cap_valid", IN_W'(cap_valid), '0);
        chk("mid_rst_dut_in", dut_in, '0);
        chk("mid_rst_signature", IN_W'(signature), '0);
        chk("mid_rst_cap_data", IN_W'(cap_data), '0);
        @(negedge clk);
        rst_n    = 1'b1;
        prev_din = '0;
        last_cap = '0;
        sig_m    = '0;
        run(4, -1, 0, caps, dones);
        chk("replay_caps", IN_W'(caps), IN_W'(4));

`ifdef VEC_PLAYER_MISR_EN
        load(0, '0);
        run(1, -1, 0, caps, dones);
        chk("misr_zero", IN_W'(signature), IN_W'(32'h0));
        load(0, IN_W'(1));
        run(1, -1, 0, caps, dones);
        chk("misr_one", IN_W'(signature), IN_W'(32'h1));
        load(1, IN_W'(1));
        run(2, -1, 0, caps, dones);
        chk("misr_two", IN_W'(signature), IN_W'(32'h3));
`endif

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int a = 0; a < DEPTH; a++) load(a, rvec());
            end
            if ($urandom_range(0, 3) == 0) load($urandom_range(4, 7), rvec());
            nv = $urandom_range(0, 7);
            n  = (nv < DEPTH) ? nv : DEPTH;
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            run(nv, ak, $urandom_range(0, 1), caps, dones);
            if (ak >= 0 && ak < n) begin
                chk("rnd_caps", IN_W'(caps), IN_W'(ak));
                chk("rnd_done", IN_W'(dones), '0);
            end else begin
                chk("rnd_caps", IN_W'(caps), IN_W'(n));
                chk("rnd_done", IN_W'(dones), IN_W'(1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
